// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the IF-stage fetch controller.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;
  localparam int unsigned DEF_CNT_W          = 32;

  // Saturation value of the wait-cycle counter at its default width.
  localparam logic [DEF_CNT_W-1:0] WAIT_SAT_DEF = '1;

endpackage

// File: rtl/fetch_wait_counter.sv
// Per-request timeout counter plus saturating memory wait-cycle counter.
module fetch_wait_counter
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             clear,
  input  logic             freeze,
  output logic             timeout_hit,
  output logic [CNT_W-1:0] wait_cycles
);

  // Timeout counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] SAT = '1;
  localparam bit TO_ENABLED = (TIMEOUT_CYCLES != 0);

  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  // Hit fires on the last no-ack cycle so the FSM enters ERR at the next edge.
  assign timeout_hit = TO_ENABLED && count_en && !freeze && (tcnt_q == TLAST);
  assign wait_cycles = wait_q;

  // Next-state: timeout count clears per request, wait count only saturates.
  always_comb begin
    tcnt_d = tcnt_q;
    wait_d = wait_q;
    if (clear)
      tcnt_d = '0;
    else if (count_en && !freeze && tcnt_q != TLAST)
      tcnt_d = tcnt_q + 1'b1;
    if (count_en && !freeze && wait_q != SAT)
      wait_d = wait_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
      wait_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer: req/ack against variable-latency imem, stall/flush
// handling, wrong-path drain and memory timeout detection.
module fetch_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_id,
  input  logic             redirect,
  input  logic             imem_ack,
  output logic             imem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_valid,
  output logic             fetch_err,
  output logic [CNT_W-1:0] wait_cycles
);

  state_e state_q, state_d;
  logic   ifid_valid_q;
  logic   valid_set;
  logic   timeout_hit;
  logic   count_en, cnt_clear, cnt_freeze;

  assign imem_req   = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign ifid_valid = ifid_valid_q;
  assign fetch_err  = (state_q == ST_ERR);

  // A request is "waiting" whenever req is up without an ack; the timeout
  // count restarts on every ack and whenever no request will be outstanding.
  assign count_en   = imem_req && !imem_ack;
  assign cnt_clear  = imem_ack || !((state_d == ST_FETCH) || (state_d == ST_DRAIN));
  assign cnt_freeze = (state_q == ST_ERR);

  fetch_wait_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .count_en   (count_en),
    .clear      (cnt_clear),
    .freeze     (cnt_freeze),
    .timeout_hit(timeout_hit),
    .wait_cycles(wait_cycles)
  );

  // Next-state and output decode; timeout beats redirect beats ack/stall.
  always_comb begin
    state_d   = state_q;
    pc_en     = 1'b0;
    ifid_en   = 1'b0;
    valid_set = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (timeout_hit) begin
          state_d = ST_ERR;
        end else if (redirect) begin
          // Flush IF/ID; if the fetch is still in flight it is wrong-path.
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          if (!imem_ack) state_d = ST_DRAIN;
        end else if (imem_ack) begin
          if (stall_id) begin
            state_d = ST_HOLD;
          end else begin
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            valid_set = 1'b1;
          end
        end else begin
          ifid_en = !stall_id;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          state_d = ST_FETCH;
        end else if (!stall_id) begin
          pc_en     = 1'b1;
          ifid_en   = 1'b1;
          valid_set = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (timeout_hit) begin
          state_d = ST_ERR;
        end else begin
          // PC already holds the target; only a further redirect moves it.
          if (redirect) begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end else begin
            ifid_en = !stall_id;
          end
          if (imem_ack) state_d = ST_FETCH;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and IF/ID valid bit; valid drops on entry to ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_ERR)
        ifid_valid_q <= 1'b0;
      else if (ifid_en)
        ifid_valid_q <= valid_set;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench: main DUT with an 8-cycle timeout, plus a 3-bit counter
// instance with the timeout disabled to exercise saturation.
module tb_fetch_controller;

  logic clk = 1'b0;
  logic rst, stall_id, redirect, imem_ack;

  logic        req_a, pc_en_a, ifid_en_a, valid_a, err_a;
  logic [31:0] wait_a;
  logic        req_b, pc_en_b, ifid_en_b, valid_b, err_b;
  logic [2:0]  wait_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_controller #(.TIMEOUT_CYCLES(8), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .stall_id(stall_id), .redirect(redirect),
    .imem_ack(imem_ack), .imem_req(req_a), .pc_en(pc_en_a),
    .ifid_en(ifid_en_a), .ifid_valid(valid_a), .fetch_err(err_a),
    .wait_cycles(wait_a)
  );

  fetch_controller #(.TIMEOUT_CYCLES(0), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .stall_id(stall_id), .redirect(redirect),
    .imem_ack(imem_ack), .imem_req(req_b), .pc_en(pc_en_b),
    .ifid_en(ifid_en_b), .ifid_valid(valid_b), .fetch_err(err_b),
    .wait_cycles(wait_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later (well before posedge).
  task automatic cyc(input logic s, input logic r, input logic a);
    @(negedge clk);
    rst = 1'b0; stall_id = s; redirect = r; imem_ack = a;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall_id = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_id = 1'b0; redirect = 1'b0; imem_ack = 1'b0;

    // Reset state
    do_reset();
    chk("rst_req", req_a, 0);
    chk("rst_pc_en", pc_en_a, 0);
    chk("rst_ifid_en", ifid_en_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_wait", wait_a, 0);

    // Ack every cycle: IDLE cycle, then one instruction per cycle
    cyc(0, 0, 1);
    chk("idle_req", req_a, 0);
    chk("idle_pc_en", pc_en_a, 0);
    cyc(0, 0, 1);
    chk("b2b_first_req", req_a, 1);
    chk("b2b_first_pc_en", pc_en_a, 1);
    chk("b2b_first_valid", valid_a, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1);
      chk("b2b_req", req_a, 1);
      chk("b2b_pc_en", pc_en_a, 1);
      chk("b2b_valid", valid_a, 1);
      chk("b2b_wait", wait_a, 0);
    end

    // Ack latency 3, no stall: pc_en every 3rd cycle, +2 waits per fetch
    for (int r = 0; r < 3; r++) begin
      cyc(0, 0, 0);
      chk("lat3_a_pc_en", pc_en_a, 0);
      chk("lat3_a_valid", valid_a, 1);
      chk("lat3_a_wait", wait_a, 2 * r);
      cyc(0, 0, 0);
      chk("lat3_b_pc_en", pc_en_a, 0);
      chk("lat3_b_valid", valid_a, 0);
      chk("lat3_b_wait", wait_a, 2 * r + 1);
      cyc(0, 0, 1);
      chk("lat3_c_pc_en", pc_en_a, 1);
      chk("lat3_c_valid", valid_a, 0);
      chk("lat3_c_wait", wait_a, 2 * r + 2);
    end

    // Ack under stall -> HOLD for 4 cycles, release loads the instruction
    cyc(1, 0, 1);
    chk("stall_ack_pc_en", pc_en_a, 0);
    chk("stall_ack_ifid_en", ifid_en_a, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0);
      chk("hold_req", req_a, 0);
      chk("hold_pc_en", pc_en_a, 0);
      chk("hold_ifid_en", ifid_en_a, 0);
    end
    cyc(0, 0, 0);
    chk("release_pc_en", pc_en_a, 1);
    chk("release_ifid_en", ifid_en_a, 1);
    cyc(0, 0, 1);
    chk("post_release_valid", valid_a, 1);
    chk("post_release_req", req_a, 1);
    chk("post_release_wait", wait_a, 6);

    // Redirect one cycle after issue with latency 3 -> DRAIN, data dropped
    cyc(0, 0, 0);
    chk("rd_issue_pc_en", pc_en_a, 0);
    cyc(0, 1, 0);
    chk("rd_pc_en", pc_en_a, 1);
    chk("rd_ifid_en", ifid_en_a, 1);
    cyc(0, 0, 1);
    chk("drain_req", req_a, 1);
    chk("drain_pc_en", pc_en_a, 0);
    chk("drain_valid", valid_a, 0);
    cyc(0, 0, 0);
    chk("refetch_req", req_a, 1);
    chk("refetch_valid", valid_a, 0);
    chk("refetch_wait", wait_a, 8);
    cyc(0, 0, 1);
    chk("refetch_ack_pc_en", pc_en_a, 1);

    // Redirect together with ack: flush, stay FETCH
    cyc(0, 1, 1);
    chk("rdack_pc_en", pc_en_a, 1);
    chk("rdack_valid_before", valid_a, 1);
    cyc(0, 0, 0);
    chk("rdack_req", req_a, 1);
    chk("rdack_valid", valid_a, 0);
    // Redirect with stall while in HOLD drops the held instruction
    cyc(1, 0, 1);
    chk("hold2_pc_en", pc_en_a, 0);
    cyc(1, 1, 0);
    chk("hold_rd_req", req_a, 0);
    chk("hold_rd_pc_en", pc_en_a, 1);
    chk("hold_rd_ifid_en", ifid_en_a, 1);
    cyc(0, 0, 1);
    chk("hold_rd_next_req", req_a, 1);
    chk("hold_rd_valid", valid_a, 0);
    chk("hold_rd_wait", wait_a, 10);

    // Timeout after 8 no-ack request cycles; sat instance keeps counting
    do_reset();
    chk("rst2_wait", wait_a, 0);
    chk("rst2_wait_sat", wait_b, 0);
    cyc(0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0);
      chk("to_req", req_a, 1);
      chk("to_wait", wait_a, k);
      if (k == 6) chk("to_k6_ifid_en", ifid_en_a, 1);
      if (k == 7) chk("to_k7_ifid_en", ifid_en_a, 0);
      if (k >= 6) chk("sat_wait_rise", wait_b, k);
    end
    cyc(0, 0, 0);
    chk("err_flag", err_a, 1);
    chk("err_req", req_a, 0);
    chk("err_pc_en", pc_en_a, 0);
    chk("err_ifid_en", ifid_en_a, 0);
    chk("err_valid", valid_a, 0);
    chk("err_wait", wait_a, 8);
    cyc(0, 1, 1);
    chk("err_sticky", err_a, 1);
    chk("err_redirect_pc_en", pc_en_a, 0);
    chk("err_wait_frozen", wait_a, 8);
    chk("sat_wait", wait_b, 7);
    chk("sat_no_err", err_b, 0);
    chk("sat_req", req_b, 1);

    do_reset();
    chk("rst3_err", err_a, 0);
    chk("rst3_wait", wait_a, 0);
    chk("rst3_req", req_a, 0);
    chk("rst3_wait_sat", wait_b, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
